result_checker: RTL

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/hw_config_pkg.sv | 9 +
 rtl/utils_pkg.sv | 20 ++
 rtl/result_checker_if.sv | 19 +
 rtl/checker_gld_ram.sv | 29 ++
 rtl/result_checker.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/hw_config_pkg.sv
// Word format shared by the DAG processor and its result checker.
package hw_config_pkg;

  // Word length in bits.
  localparam int BIT_L = 32;

  typedef logic [BIT_L-1:0] word_t;

endpackage

// File: rtl/utils_pkg.sv
// Shared utility types and constants: checker FSM states, default tolerance
// and a saturating counter helper.
package utils_pkg;

  // Default absolute tolerance, in LSBs, for a matching word.
  localparam int TOL_DEFAULT = 1024;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_RUN   = 2'd1,
    CHK_DRAIN = 2'd2,
    CHK_DONE  = 2'd3
  } chk_state_e;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/result_checker_if.sv
// Result stream from the DAG processor output stage into the checker.
//
// Handshake: the master holds res_vld, res_addr and res_data stable while
// res_vld=1; the slave raises res_rdy when it can accept. A word moves on every
// rising clk edge where res_vld & res_rdy are both 1, at most one per cycle.
// res_rdy does not depend combinationally on res_vld.
interface result_checker_if #(
  parameter int N_WORDS = 256
);

  logic                       res_vld;
  logic                       res_rdy;
  logic [$clog2(N_WORDS)-1:0] res_addr;
  hw_config_pkg::word_t       res_data;

  modport master (output res_vld, res_addr, res_data, input res_rdy);
  modport slave  (input res_vld, res_addr, res_data, output res_rdy);

endinterface

// File: rtl/checker_gld_ram.sv
// Golden store: N_WORDS x word_t, one write port and one synchronous read
// port. Contents are never reset.
module checker_gld_ram
  import hw_config_pkg::*;
#(
  parameter int N_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(N_WORDS)-1:0] waddr,
  input  word_t                      wdata,
  input  logic                       re,
  input  logic [$clog2(N_WORDS)-1:0] raddr,
  output word_t                      rdata
);

  word_t mem [N_WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port; output holds between reads.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/result_checker.sv
// result_checker: compares a stream of DAG results against a golden store
// within an absolute tolerance and reports counts and a pass flag.
// Optional feature macro: CHECKER_FIRST_ERR_EN (first-mismatch capture).
module result_checker
  import hw_config_pkg::*;
  import utils_pkg::*;
#(
  parameter int N_WORDS = 256,
  parameter int TOL     = TOL_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       gld_we,
  input  logic [$clog2(N_WORDS)-1:0] gld_addr,
  input  word_t                      gld_data,
  input  logic                       start,
  input  logic [$clog2(N_WORDS):0]   n_expected,
  result_checker_if.slave            res,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                chk_cnt,
  output logic [15:0]                err_cnt,
  output logic                       first_err_vld,
  output logic [$clog2(N_WORDS)-1:0] first_err_addr,
  output word_t                      first_err_data,
  output chk_state_e                 dbg_state
);

  localparam int AW = $clog2(N_WORDS);
  localparam int CW = AW + 1;
  localparam logic [BIT_L:0] TOL_W = (BIT_L+1)'(TOL);

  chk_state_e      state, state_nxt;
  logic            rdy;
  logic            xfer, last_xfer, start_acc;
  logic [CW-1:0]   n_lat, xfer_cnt;
  logic            cmp_vld;
  word_t           cmp_data;
  word_t           gld_rdata;
  logic [BIT_L:0]  diff;
  logic            match, mismatch;
  logic [15:0]     err_nxt;

  assign xfer      = res.res_vld & rdy;
  assign last_xfer = xfer && (xfer_cnt == n_lat - 1'b1);
  // A new run can only be launched from IDLE or DONE; start is ignored while busy.
  assign start_acc = start && ((state == CHK_IDLE) || (state == CHK_DONE));
  assign res.res_rdy = rdy;
  assign dbg_state   = state;

  checker_gld_ram #(.N_WORDS(N_WORDS)) u_gld_ram (
    .clk   (clk),
    .we    (gld_we && (state == CHK_IDLE)),
    .waddr (gld_addr),
    .wdata (gld_data),
    .re    (xfer),
    .raddr (res.res_addr),
    .rdata (gld_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CHK_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      CHK_IDLE: begin
        if (start) state_nxt = (n_expected == '0) ? CHK_DONE : CHK_RUN;
      end
      CHK_RUN: begin
        rdy  = 1'b1;
        busy = 1'b1;
        if (last_xfer) state_nxt = CHK_DRAIN;
      end
      CHK_DRAIN: begin
        busy      = 1'b1;
        state_nxt = CHK_DONE;
      end
      CHK_DONE: begin
        done = 1'b1;
        if (start) state_nxt = (n_expected == '0) ? CHK_DONE : CHK_RUN;
        else       state_nxt = CHK_IDLE;
      end
      default: state_nxt = CHK_IDLE;
    endcase
  end

  // Tolerance compare on the registered result against the golden read-out;
  // one extra bit keeps the subtraction free of wrap at 0 and at max word.
  always_comb begin
    if ({1'b0, gld_rdata} >= {1'b0, cmp_data}) diff = {1'b0, gld_rdata} - {1'b0, cmp_data};
    else                                       diff = {1'b0, cmp_data} - {1'b0, gld_rdata};
    match    = (diff <= TOL_W);
    mismatch = cmp_vld && !match;
    err_nxt  = mismatch ? sat_inc16(err_cnt) : err_cnt;
  end

  // Run bookkeeping, compare pipeline stage, counters and pass flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat    <= '0;
      xfer_cnt <= '0;
      cmp_vld  <= 1'b0;
      cmp_data <= '0;
      chk_cnt  <= '0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      cmp_vld <= xfer;
      if (xfer) cmp_data <= res.res_data;
      if (start_acc) begin
        n_lat    <= n_expected;
        xfer_cnt <= '0;
        chk_cnt  <= '0;
        err_cnt  <= '0;
        pass     <= (n_expected == '0);
      end else begin
        if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
        if (cmp_vld) begin
          chk_cnt <= sat_inc16(chk_cnt);
          err_cnt <= err_nxt;
        end
        // Pass is valid only for the DONE cycle that follows DRAIN.
        pass <= (state == CHK_DRAIN) && (err_nxt == 16'd0);
      end
    end
  end

`ifdef CHECKER_FIRST_ERR_EN
  logic [AW-1:0] cmp_addr;

  // Address travels alongside the data through the compare stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cmp_addr <= '0;
    else if (xfer) cmp_addr <= res.res_addr;
  end

  // First mismatch of a run is captured and held until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (start_acc) begin
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_data <= '0;
    end else if (mismatch && !first_err_vld) begin
      first_err_vld  <= 1'b1;
      first_err_addr <= cmp_addr;
      first_err_data <= cmp_data;
    end
  end
`else
  assign first_err_vld  = 1'b0;
  assign first_err_addr = '0;
  assign first_err_data = '0;
`endif

endmodule
